// File: rtl/pipeline_exec_control_pkg.sv
// Shared defs for the pipeline execution controller:
// debug command codes, FSM state encodings, default widths.
package pipeline_exec_control_pkg;

  localparam int          DEF_NB_OPCODE   = 6;
  localparam logic [5:0]  DEF_HALT_OPCODE = 6'h3f;
  localparam int          DEF_N_DRAIN     = 4;
  localparam int          DEF_NB_CYCLES   = 32;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_RUN   = 2'b01,
    CMD_STEP  = 2'b10,
    CMD_ABORT = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/pipeline_exec_control_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones.
// Used for the enabled-cycle count.
module pipeline_exec_control_sat_counter #(
  parameter int NB = 32
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_enable,
  output logic [NB-1:0] o_count
);

  logic [NB-1:0] cnt_q;
  logic [NB-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_enable && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign o_count = cnt_q;

endmodule

// File: rtl/pipeline_exec_control.sv
// Debug-driven run/step/abort sequencer for the MIPS pipeline:
// gates the global enable, drains after HALT, counts cycles.
module pipeline_exec_control
  import pipeline_exec_control_pkg::*;
#(
  parameter int                 NB_OPCODE   = DEF_NB_OPCODE,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE = DEF_HALT_OPCODE,
  parameter int                 N_DRAIN     = DEF_N_DRAIN,
  parameter int                 NB_CYCLES   = DEF_NB_CYCLES
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_cmd_valid,
  input  logic [1:0]           i_cmd,
  output logic                 o_cmd_ready,
  input  logic [NB_OPCODE-1:0] i_opcode,
  output logic                 o_pipe_enable,
  output logic                 o_halted,
  output logic [2:0]           o_state,
  output logic [NB_CYCLES-1:0] o_cycle_count
);

  localparam int ND_W = $clog2(N_DRAIN + 1);
  localparam logic [ND_W-1:0] DRAIN_LOAD = ND_W'(N_DRAIN - 1);

  state_e          state_q, state_d;
  logic [ND_W-1:0] drain_q, drain_d;
  logic            pipe_en;
  logic            ready;
  logic            halted;
  logic            halt_op;
  logic            take;
  cmd_e            cmd;

  assign halt_op = (i_opcode == HALT_OPCODE);
  assign cmd     = cmd_e'(i_cmd);
  assign take    = i_cmd_valid && ready;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    pipe_en = 1'b0;
    ready   = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_PAUSE: begin
        ready = 1'b1;
        if (i_cmd_valid) begin
          unique case (cmd)
            CMD_RUN:   state_d = ST_RUN;
            CMD_STEP:  state_d = ST_STEP;
            CMD_ABORT: state_d = ST_DONE;
            default:   state_d = state_q;
          endcase
        end
      end
      ST_RUN: begin
        ready   = 1'b1;
        pipe_en = 1'b1;
        // HALT outranks a same-cycle ABORT
        if (halt_op && pipe_en) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (i_cmd_valid && (cmd == CMD_ABORT)) begin
          state_d = ST_DONE;
        end
      end
      ST_STEP: begin
        pipe_en = 1'b1;
        if (halt_op && pipe_en) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_DRAIN: begin
        pipe_en = 1'b1;
        if (drain_q == '0) state_d = ST_DONE;
        else               drain_d = drain_q - 1'b1;
      end
      ST_DONE: begin
        halted = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  pipeline_exec_control_sat_counter #(
    .NB(NB_CYCLES)
  ) u_cycles (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_enable(pipe_en),
    .o_count (o_cycle_count)
  );

  assign o_cmd_ready   = ready;
  assign o_pipe_enable = pipe_en;
  assign o_halted      = halted;
  assign o_state       = state_q;

  logic unused_take;
  assign unused_take = take;

endmodule

// File: tb/tb_pipeline_exec_control.sv
// Directed bench for pipeline_exec_control: reset, run, step,
// abort, HALT/ABORT collision, counter saturation.
module tb_pipeline_exec_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic        cmd_ready;
  logic [5:0]  opcode;
  logic        pipe_en;
  logic        halted;
  logic [2:0]  state;
  logic [31:0] count;

  logic        s_rst;
  logic        s_cmd_valid;
  logic [1:0]  s_cmd;
  logic        s_cmd_ready;
  logic [5:0]  s_opcode;
  logic        s_pipe_en;
  logic        s_halted;
  logic [2:0]  s_state;
  logic [3:0]  s_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_exec_control dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_cmd_valid  (cmd_valid),
    .i_cmd        (cmd),
    .o_cmd_ready  (cmd_ready),
    .i_opcode     (opcode),
    .o_pipe_enable(pipe_en),
    .o_halted     (halted),
    .o_state      (state),
    .o_cycle_count(count)
  );

  pipeline_exec_control #(
    .NB_CYCLES(4)
  ) dut_s (
    .i_clock      (clk),
    .i_reset      (s_rst),
    .i_cmd_valid  (s_cmd_valid),
    .i_cmd        (s_cmd),
    .o_cmd_ready  (s_cmd_ready),
    .i_opcode     (s_opcode),
    .o_pipe_enable(s_pipe_en),
    .o_halted     (s_halted),
    .o_state      (s_state),
    .o_cycle_count(s_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag,
                         input logic [2:0] st,
                         input logic en,
                         input logic rdy,
                         input logic hlt,
                         input logic [31:0] cnt);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".en"},    32'(pipe_en), 32'(en));
    chk({tag, ".rdy"},   32'(cmd_ready), 32'(rdy));
    chk({tag, ".hlt"},   32'(halted), 32'(hlt));
    chk({tag, ".cnt"},   count, cnt);
  endtask

  task automatic send(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd       = c;
    cyc(1);
    cmd_valid = 1'b0;
    cmd       = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; opcode = 6'h00;
    s_rst = 1'b1; s_cmd_valid = 1'b0; s_cmd = 2'b00; s_opcode = 6'h00;
    cyc(2);
    chk_all("rst", 3'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    rst = 1'b0;
    s_rst = 1'b0;
    cyc(1);
    chk_all("idle", 3'd0, 1'b0, 1'b1, 1'b0, 32'd0);

    // T1: async reset mid-RUN
    send(2'b01);
    cyc(3);
    chk("t1.pre.cnt", count, 32'd3);
    #2 rst = 1'b1;
    #1;
    chk_all("t1.async", 3'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    rst = 1'b0;
    cyc(1);

    // T2: run 10, HALT, drain 4, done
    do_reset();
    send(2'b01);
    chk_all("t2.run0", 3'd1, 1'b1, 1'b1, 1'b0, 32'd0);
    cyc(10);
    chk("t2.run10.cnt", count, 32'd10);
    opcode = 6'h3f;
    cyc(1);
    opcode = 6'h00;
    chk_all("t2.drain0", 3'd4, 1'b1, 1'b0, 1'b0, 32'd11);
    cyc(3);
    chk_all("t2.drain3", 3'd4, 1'b1, 1'b0, 1'b0, 32'd14);
    cyc(1);
    chk_all("t2.done", 3'd5, 1'b0, 1'b0, 1'b1, 32'd15);
    opcode = 6'h3f;
    cyc(3);
    opcode = 6'h00;
    chk_all("t2.sticky", 3'd5, 1'b0, 1'b0, 1'b1, 32'd15);

    // T3: three steps with gaps, HALT on the fourth
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(2'b10);
      chk_all("t3.step", 3'd2, 1'b1, 1'b0, 1'b0, 32'(i));
      cyc(1);
      chk_all("t3.pause", 3'd3, 1'b0, 1'b1, 1'b0, 32'(i + 1));
      cyc(2);
      chk("t3.gap.cnt", count, 32'(i + 1));
    end
    send(2'b10);
    opcode = 6'h3f;
    cyc(1);
    opcode = 6'h00;
    chk_all("t3.drain0", 3'd4, 1'b1, 1'b0, 1'b0, 32'd4);
    cyc(3);
    chk("t3.drain3.st", 32'(state), 32'd4);
    cyc(1);
    chk_all("t3.done", 3'd5, 1'b0, 1'b0, 1'b1, 32'd8);

    // T4: abort from RUN; later commands ignored
    do_reset();
    send(2'b01);
    cyc(4);
    chk("t4.run.cnt", count, 32'd4);
    send(2'b11);
    chk_all("t4.done", 3'd5, 1'b0, 1'b0, 1'b1, 32'd5);
    cmd_valid = 1'b1;
    cmd = 2'b01;
    cyc(2);
    cmd_valid = 1'b0;
    chk_all("t4.ign", 3'd5, 1'b0, 1'b0, 1'b1, 32'd5);

    // Abort from IDLE
    do_reset();
    send(2'b11);
    chk_all("t4.idleab", 3'd5, 1'b0, 1'b0, 1'b1, 32'd0);

    // T5: HALT and ABORT together in RUN
    do_reset();
    send(2'b01);
    cyc(2);
    opcode = 6'h3f;
    send(2'b11);
    opcode = 6'h00;
    chk_all("t5.drain", 3'd4, 1'b1, 1'b0, 1'b0, 32'd3);
    cyc(4);
    chk_all("t5.done", 3'd5, 1'b0, 1'b0, 1'b1, 32'd7);

    // NOP in PAUSE holds; RUN from PAUSE
    do_reset();
    send(2'b10);
    cyc(1);
    send(2'b00);
    chk("pause.nop.st", 32'(state), 32'd3);
    send(2'b01);
    chk("pause.run.st", 32'(state), 32'd1);

    // T6: 4-bit counter saturates; reset mid-DRAIN
    s_cmd_valid = 1'b1;
    s_cmd = 2'b01;
    cyc(1);
    s_cmd_valid = 1'b0;
    cyc(20);
    chk("t6.sat.cnt", 32'(s_count), 32'd15);
    chk("t6.sat.st", 32'(s_state), 32'd1);
    s_opcode = 6'h3f;
    cyc(1);
    s_opcode = 6'h00;
    cyc(1);
    chk("t6.drain.st", 32'(s_state), 32'd4);
    #2 s_rst = 1'b1;
    #1;
    chk("t6.rst.st", 32'(s_state), 32'd0);
    chk("t6.rst.cnt", 32'(s_count), 32'd0);
    chk("t6.rst.en", 32'(s_pipe_en), 32'd0);
    chk("t6.rst.rdy", 32'(s_cmd_ready), 32'd1);
    s_rst = 1'b0;
    cyc(6);
    chk("t6.stay.st", 32'(s_state), 32'd0);
    chk("t6.stay.hlt", 32'(s_halted), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
